// File: rtl/sram_addr_gen.sv
// Serial-loaded SRAM address counter for the AVR-SRAM bus path.
// The AVR shifts an address in MSB-first, then a rising avr_sreg_en makes it live and steppable.
module sram_addr_gen #(
  parameter int ADDR_WIDTH = 21,
  parameter int STEP       = 1
) (
  input  logic                  avr_clk,
  input  logic                  avr_reset,
  input  logic                  avr_si,
  input  logic                  avr_sreg_en,
  input  logic [2:0]            avr_ctrl,
  input  logic                  access_done,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  addr_valid,
  output logic                  avr_so,
  output logic                  wrap
);

  typedef enum logic [1:0] {SHIFT, LOAD, RUN} state_t;

  // One extra bit so the carry or borrow out of the counter falls into the MSB.
  localparam logic [ADDR_WIDTH:0] STEP_EXT = (ADDR_WIDTH+1)'(STEP);

  state_t                state;
  state_t                state_next;
  logic                  en_q;
  logic [ADDR_WIDTH-1:0] buffer;
  logic [ADDR_WIDTH-1:0] buffer_next;
  logic                  load_now;
  logic                  step_now;
  logic [ADDR_WIDTH:0]   sum_up;
  logic [ADDR_WIDTH:0]   sum_dn;

  // The buffer shifts on every edge that sees avr_sreg_en low, whatever the state.
  assign buffer_next = avr_sreg_en ? buffer : {buffer[ADDR_WIDTH-2:0], avr_si};
  assign load_now    = (state == SHIFT) && avr_sreg_en && !en_q;
  assign step_now    = (state == RUN) && avr_sreg_en && access_done &&
                       avr_ctrl[0] && !avr_ctrl[2];
  assign sum_up      = {1'b0, sram_addr} + STEP_EXT;
  assign sum_dn      = {1'b0, sram_addr} - STEP_EXT;

  always_ff @(posedge avr_clk or negedge avr_reset) begin
    if (!avr_reset) begin
      state <= SHIFT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SHIFT:   if (load_now) state_next = LOAD;
      LOAD:    state_next = avr_sreg_en ? RUN : SHIFT;
      RUN:     if (!avr_sreg_en) state_next = SHIFT;
      default: state_next = SHIFT;
    endcase
  end

  always_comb begin
    addr_valid = (state == RUN);
  end

  // A load and a step can never coincide: loads only happen in SHIFT, steps only in RUN.
  always_ff @(posedge avr_clk or negedge avr_reset) begin
    if (!avr_reset) begin
      en_q      <= 1'b0;
      buffer    <= '0;
      avr_so    <= 1'b0;
      sram_addr <= '0;
      wrap      <= 1'b0;
    end else begin
      en_q   <= avr_sreg_en;
      buffer <= buffer_next;
      avr_so <= buffer_next[ADDR_WIDTH-1];
      wrap   <= 1'b0;
      if (load_now) begin
        sram_addr <= buffer;
      end else if (step_now) begin
        if (avr_ctrl[1]) begin
          {wrap, sram_addr} <= sum_dn;
        end else begin
          {wrap, sram_addr} <= sum_up;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_addr_gen.sv
// Self-checking bench for sram_addr_gen: expectations are queued as stimulus is driven
// and compared against sram_addr/addr_valid/wrap one edge later.
module tb_sram_addr_gen;

  localparam int W = 21;

  logic         avr_clk = 1'b0;
  logic         avr_reset;
  logic         avr_si;
  logic         avr_sreg_en;
  logic [2:0]   avr_ctrl;
  logic         access_done;
  logic [W-1:0] sram_addr;
  logic         addr_valid;
  logic         avr_so;
  logic         wrap;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] addr;
    logic         valid;
    logic         wrap;
  } exp_t;

  exp_t sb[$];

  sram_addr_gen #(.ADDR_WIDTH(W), .STEP(1)) dut (
    .avr_clk     (avr_clk),
    .avr_reset   (avr_reset),
    .avr_si      (avr_si),
    .avr_sreg_en (avr_sreg_en),
    .avr_ctrl    (avr_ctrl),
    .access_done (access_done),
    .sram_addr   (sram_addr),
    .addr_valid  (addr_valid),
    .avr_so      (avr_so),
    .wrap        (wrap)
  );

  always #5 avr_clk = ~avr_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expect_next(input string tag, input logic [W-1:0] a, input logic v,
                             input logic w);
    exp_t e;
    e.tag   = tag;
    e.addr  = a;
    e.valid = v;
    e.wrap  = w;
    sb.push_back(e);
  endtask

  // Advance one edge, then score whatever expectation was queued for it.
  task automatic tick();
    exp_t e;
    @(posedge avr_clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.tag, "_addr"}, 32'(sram_addr), 32'(e.addr));
      checkOutput({e.tag, "_valid"}, 32'(addr_valid), 32'(e.valid));
      checkOutput({e.tag, "_wrap"}, 32'(wrap), 32'(e.wrap));
    end
  endtask

  task automatic shift_word(input logic [W-1:0] value);
    for (int i = W - 1; i >= 0; i--) begin
      avr_sreg_en = 1'b0;
      avr_si      = value[i];
      tick();
    end
  endtask

  task automatic load_word(input string tag, input logic [W-1:0] value);
    shift_word(value);
    avr_sreg_en = 1'b1;
    expect_next({tag, "_ld"}, value, 1'b0, 1'b0);
    tick();
    expect_next({tag, "_run"}, value, 1'b1, 1'b0);
    tick();
  endtask

  // One access_done strobe followed by an idle cycle in which wrap must be low again.
  task automatic pulse_done(input string tag, input logic [W-1:0] a, input logic w);
    access_done = 1'b1;
    expect_next({tag, "_step"}, a, 1'b1, w);
    tick();
    access_done = 1'b0;
    expect_next({tag, "_idle"}, a, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    logic [W-1:0] old_buf;
    logic [W-1:0] new_buf;

    avr_reset   = 1'b0;
    avr_si      = 1'b0;
    avr_sreg_en = 1'b0;
    avr_ctrl    = 3'b000;
    access_done = 1'b0;
    repeat (2) @(posedge avr_clk);
    #1;
    checkOutput("rst_addr", 32'(sram_addr), 32'h0);
    checkOutput("rst_valid", 32'(addr_valid), 32'h0);
    checkOutput("rst_wrap", 32'(wrap), 32'h0);
    checkOutput("rst_so", 32'(avr_so), 32'h0);
    #3 avr_reset = 1'b1;

    load_word("shift", 21'h1ABCDE);

    load_word("burst", 21'h000010);
    avr_ctrl = 3'b001;
    pulse_done("inc1", 21'h000011, 1'b0);
    pulse_done("inc2", 21'h000012, 1'b0);
    pulse_done("inc3", 21'h000013, 1'b0);
    pulse_done("inc4", 21'h000014, 1'b0);
    avr_ctrl = 3'b101;
    pulse_done("hold1", 21'h000014, 1'b0);
    pulse_done("hold2", 21'h000014, 1'b0);
    avr_ctrl = 3'b000;
    pulse_done("noinc", 21'h000014, 1'b0);

    load_word("wrapld", 21'h1FFFFF);
    avr_ctrl = 3'b001;
    pulse_done("wrapup", 21'h000000, 1'b1);
    avr_ctrl = 3'b011;
    pulse_done("wrapdn", 21'h1FFFFF, 1'b1);
    pulse_done("dec", 21'h1FFFFE, 1'b0);

    // Load collides with access_done; the strobe is also held through LOAD.
    avr_ctrl = 3'b001;
    shift_word(21'h000100);
    avr_sreg_en = 1'b1;
    access_done = 1'b1;
    expect_next("coll_ld", 21'h000100, 1'b0, 1'b0);
    tick();
    expect_next("coll_loadst", 21'h000100, 1'b1, 1'b0);
    tick();
    access_done = 1'b0;
    expect_next("coll_run", 21'h000100, 1'b1, 1'b0);
    tick();
    pulse_done("coll_inc", 21'h000101, 1'b0);

    // Re-shift from RUN: the old buffer comes back out on avr_so MSB-first.
    load_word("rs", 21'h000020);
    old_buf = 21'h000020;
    new_buf = 21'h000055;
    for (int i = W - 1; i >= 0; i--) begin
      checkOutput("rs_so", 32'(avr_so), 32'(old_buf[i]));
      avr_sreg_en = 1'b0;
      avr_si      = new_buf[i];
      expect_next("rs_shift", 21'h000020, 1'b0, 1'b0);
      tick();
    end
    avr_sreg_en = 1'b1;
    expect_next("rs_ld", 21'h000055, 1'b0, 1'b0);
    tick();
    expect_next("rs_run", 21'h000055, 1'b1, 1'b0);
    tick();

    // Asynchronous reset in the middle of a shift.
    new_buf = 21'h1FFFFF;
    for (int i = W - 1; i >= W - 10; i--) begin
      avr_sreg_en = 1'b0;
      avr_si      = new_buf[i];
      tick();
    end
    #3 avr_reset = 1'b0;
    #1;
    checkOutput("mid_rst_addr", 32'(sram_addr), 32'h0);
    checkOutput("mid_rst_valid", 32'(addr_valid), 32'h0);
    checkOutput("mid_rst_wrap", 32'(wrap), 32'h0);
    checkOutput("mid_rst_so", 32'(avr_so), 32'h0);
    #2 avr_reset = 1'b1;
    load_word("post_rst", 21'h0000AA);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_addr_gen.md
Name: sram_addr_gen

Overview:
- Upstream address stage for the AVR–SRAM bus path.
- Receives a serial SRAM address from the AVR (avr_si, MSB first) while avr_sreg_en is low.
- On the rising edge of avr_sreg_en, transfers the shifted address into a live address counter that drives sram_addr.
- Post-increments or post-decrements the counter on each access_done strobe from the bus state machine, so the AVR can stream bursts without reshifting.

Parameters:
- ADDR_WIDTH, 21: width of shift buffer, counter and sram_addr.
- STEP, 1: amount added or subtracted per access_done; modulo 2^ADDR_WIDTH.

Ports:
- avr_clk  input  1  system clock, all logic on rising edge.
- avr_reset  input  1  asynchronous reset, active-low.
- avr_si  input  1  serial address bit, MSB first.
- avr_sreg_en  input  1  low = shift mode; high = address live.
- avr_ctrl  input  3  mode: [0] autoinc enable, [1] direction (0 up, 1 down), [2] hold (freeze counter).
- access_done  input  1  one-cycle strobe from the bus FSM: an SRAM access completed.
- sram_addr  output  ADDR_WIDTH  current SRAM address.
- addr_valid  output  1  high while in RUN.
- avr_so  output  1  serial readback: buffer MSB.
- wrap  output  1  one-cycle pulse when the counter wraps.

Behaviour:
- Reset (avr_reset=0, asynchronous):
  - buffer=0, sram_addr=0, addr_valid=0, wrap=0, avr_so=0.
  - en_q (registered avr_sreg_en) =0, state=SHIFT.
- FSM states: SHIFT, LOAD, RUN. en_q is updated every cycle.
- SHIFT:
  - Each clock with avr_sreg_en=0: buffer <= {buffer[W-2:0], avr_si}.
  - sram_addr holds its last value; addr_valid=0.
  - avr_sreg_en=1 with en_q=0 -> LOAD.
- LOAD (exactly one cycle):
  - At the edge that enters LOAD, sram_addr <= buffer.
  - addr_valid rises at the next edge, when the FSM enters RUN.
  - Latency: avr_sreg_en sampled high at edge k -> sram_addr=buffer after edge k -> addr_valid=1 after edge k+1.
  - access_done during LOAD is ignored.
  - If avr_sreg_en=0 during LOAD -> SHIFT.
- RUN:
  - addr_valid=1; buffer is frozen (no shifting).
  - access_done=1, avr_ctrl[0]=1, avr_ctrl[2]=0: sram_addr += STEP (dir=0) or -= STEP (dir=1) at that edge, modulo 2^W.
  - access_done with autoinc=0 or hold=1: no change.
  - avr_sreg_en=0 -> SHIFT. addr_valid drops at that edge; sram_addr keeps its value; shifting starts on the same edge.
- Wrap:
  - Up from 2^W-1 to 0, or down from 0 to 2^W-1: wrap=1 for exactly the following cycle.
  - Otherwise wrap=0.
  - With STEP>1, wrap fires whenever the arithmetic carries or borrows out of W bits.
- avr_so:
  - Always equals buffer[W-1], registered.
  - Shifting W bits out in SHIFT mode echoes the previously loaded buffer.
- Simultaneous events:
  - A rising avr_sreg_en edge and access_done in the same cycle: load wins, increment is dropped.
  - avr_ctrl changes take effect on the same edge as access_done.
- Reset mid-operation: immediate return to reset values; a partially shifted address is lost.
- avr_sreg_en held high continuously: only one LOAD. Repeated LOAD needs a low cycle first.

Test Plan:
- Shift load:
  - Reset, shift 21 bits of 0x1ABCDE MSB-first with avr_sreg_en=0, raise avr_sreg_en.
  - -> sram_addr=0x1ABCDE one edge later; addr_valid=1 the edge after; wrap=0.
- Auto-increment burst:
  - Load 0x000010, avr_ctrl=3'b001, pulse access_done 4 times.
  - -> sram_addr 0x11, 0x12, 0x13, 0x14.
  - Set avr_ctrl=3'b101, pulse twice -> stays 0x14.
- Wrap up and down:
  - Load 0x1FFFFF, ctrl=001, one access_done -> sram_addr=0, wrap pulses one cycle.
  - ctrl=011, one access_done -> sram_addr=0x1FFFFF, wrap pulses again.
- Collision and ignore cases:
  - access_done asserted on the same edge avr_sreg_en rises with buffer=0x000100 -> sram_addr=0x000100, not 0x101.
  - access_done during LOAD -> ignored.
- Re-shift and readback:
  - In RUN at 0x000020, drop avr_sreg_en -> addr_valid=0 next edge, sram_addr still 0x20.
  - Shift 21 bits of 0x000055 -> avr_so emits the old buffer 0x000020 MSB-first.
  - Raise avr_sreg_en -> sram_addr=0x55.
- Reset mid-shift:
  - Assert avr_reset low asynchronously between clock edges after 10 shifted bits.
  - -> all outputs 0 immediately; after release, a full 21-bit shift of 0x0000AA loads 0x0000AA.
